// File: rtl/des_round_engine.sv
// rtl/des_round_engine.sv - iterative DES Feistel core, one round per clock
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   set             start strobe, honoured only in IDLE
//   data_in[0:63]   IP-permuted block L0||R0 (bit 0 is DES bit 1)
//   key_in[0:63]    raw DES key; parity bits are dropped by PC-1
//   decrypt         1 = apply subkeys K16..K1 (present only with DES_DECRYPT_EN)
//   data_out[0:63]  pre-output R16||L16, held until the next completion
//   status          one-cycle completion pulse
//   busy            registered, high while a block is in flight
//
// Build option: DES_DECRYPT_EN adds the decrypt port and right-rotation schedule.
module des_round_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [0:63] data_in,
  input  logic [0:63] key_in,
`ifdef DES_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic [0:63] data_out,
  output logic        status,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box packed row-major, row 0 in the most significant nibbles.
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] o;
    for (int i = 0; i < 56; i++) o[i] = k[PC1_TAB[i] - 1];
    return o;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] o;
    for (int i = 0; i < 48; i++) o[i] = cd[PC2_TAB[i] - 1];
    return o;
  endfunction

  function automatic logic [0:27] rol(input logic [0:27] v, input logic two);
    return two ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic logic [0:27] ror(input logic [0:27] v, input logic two);
    return two ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
  endfunction
`endif

  function automatic logic [3:0] sbox(input int n, input logic [0:5] b);
    int k;
    // row from the outer bits, column from the inner four
    k = 32 * int'(b[0]) + 16 * int'(b[5]) + int'({b[1], b[2], b[3], b[4]});
    return SBOX_TAB[n][255 - 4 * k -: 4];
  endfunction

  function automatic logic [0:31] feistel(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:31] s;
    logic [0:31] o;
    // E expansion: group j takes R bits 4j-1 .. 4j+4 with wrap-around
    for (int j = 0; j < 8; j++)
      for (int m = 0; m < 6; m++)
        x[6 * j + m] = r[(4 * j + m + 31) % 32] ^ k[6 * j + m];
    for (int j = 0; j < 8; j++) s[4 * j +: 4] = sbox(j, x[6 * j +: 6]);
    for (int i = 0; i < 32; i++) o[i] = s[P_TAB[i] - 1];
    return o;
  endfunction

  state_t      state;
  logic [4:0]  rnd;
  logic [0:31] l_reg, r_reg;
  logic [0:27] c_reg, d_reg;
  logic [0:27] c_next, d_next;
  logic [0:47] subkey;
  logic [0:31] f_out;
  logic        one_step;
`ifdef DES_DECRYPT_EN
  logic        dec_reg;
`endif

  assign one_step = (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);

  always_comb begin
    c_next = rol(c_reg, !one_step);
    d_next = rol(d_reg, !one_step);
`ifdef DES_DECRYPT_EN
    // Decrypt walks the schedule backwards: K16 is PC-2 of the unrotated C0||D0.
    if (dec_reg) begin
      if (rnd == 5'd1) begin
        c_next = c_reg;
        d_next = d_reg;
      end else begin
        c_next = ror(c_reg, !one_step);
        d_next = ror(d_reg, !one_step);
      end
    end
`endif
    subkey = pc2({c_next, d_next});
    f_out  = feistel(r_reg, subkey);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rnd      <= 5'd0;
      l_reg    <= '0;
      r_reg    <= '0;
      c_reg    <= '0;
      d_reg    <= '0;
      data_out <= '0;
      status   <= 1'b0;
      busy     <= 1'b0;
`ifdef DES_DECRYPT_EN
      dec_reg  <= 1'b0;
`endif
    end else begin
      status <= 1'b0;
      // busy trails the state by one edge, so it rises as LOAD completes
      busy   <= (state != S_IDLE);
      case (state)
        S_IDLE: if (set) state <= S_LOAD;
        S_LOAD: begin
          l_reg          <= data_in[0:31];
          r_reg          <= data_in[32:63];
          {c_reg, d_reg} <= pc1(key_in);
`ifdef DES_DECRYPT_EN
          dec_reg        <= decrypt;
`endif
          rnd            <= 5'd1;
          state          <= S_ROUND;
        end
        S_ROUND: begin
          c_reg <= c_next;
          d_reg <= d_next;
          l_reg <= r_reg;
          r_reg <= l_reg ^ f_out;
          if (rnd == 5'd16) state <= S_DONE;
          else rnd <= rnd + 5'd1;
        end
        S_DONE: begin
          data_out <= {r_reg, l_reg};
          status   <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// tb/tb_des_round_engine.sv - directed bench for des_round_engine
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        set;
  logic [0:63] data_in;
  logic [0:63] key_in;
  logic [0:63] data_out;
  logic        status;
  logic        busy;
`ifdef DES_DECRYPT_EN
  logic        decrypt;
`endif

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;
  int first;

  localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
  localparam logic [63:0] BLK   = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] EXP   = 64'h0A4CD99543423234;
  // complemented vector: DES(~k, ~p) = ~DES(k, p), and IP commutes with ~
  localparam logic [63:0] KEY_N = 64'hECCBA8866443200E;
  localparam logic [63:0] BLK_N = 64'h33FF33000F550F55;
  localparam logic [63:0] EXP_N = 64'hF5B3266ABCBDCDCB;

  des_round_engine dut (
    .clk      (clk),
    .rst      (rst),
    .set      (set),
    .data_in  (data_in),
    .key_in   (key_in),
`ifdef DES_DECRYPT_EN
    .decrypt  (decrypt),
`endif
    .data_out (data_out),
    .status   (status),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive a request at the current negedge; returns at the negedge after edge 0
  task automatic issue(input logic [63:0] k, input logic [63:0] d);
    key_in  = k;
    data_in = d;
    set     = 1'b1;
    @(negedge clk);
    set     = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (status !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; set = 1'b0; data_in = '0; key_in = '0;
`ifdef DES_DECRYPT_EN
    decrypt = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_data_out", data_out, 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (status) pulses++;
    end
    check("idle_no_status", 64'(pulses), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // standard vector
    issue(KEY, BLK);
    wait_done(lat);
    check("std_latency", 64'(lat), 64'd18);
    check("std_data", data_out, EXP);
    @(negedge clk);
    check("std_status_one_cycle", 64'(status), 64'd0);
    check("std_busy_clear", 64'(busy), 64'd0);
    check("std_data_held", data_out, EXP);

    // busy lockout, then a new request accepted at edge 19
    @(negedge clk);
    issue(KEY, BLK);
    pulses = 0;
    first  = 0;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) check("lock_busy_after_load", 64'(busy), 64'd1);
      if (status) begin
        pulses++;
        if (first == 0) first = n;
      end
      if (n == 3 || n == 10 || n == 18) begin
        key_in  = KEY_N;
        data_in = BLK_N;
        set     = 1'b1;
      end else begin
        set = 1'b0;
      end
    end
    check("lock_pulses", 64'(pulses), 64'd1);
    check("lock_latency", 64'(first), 64'd18);
    check("lock_data", data_out, EXP);
    @(negedge clk);
    set = 1'b0;
    check("lock_status_low", 64'(status), 64'd0);
    check("lock_busy_low", 64'(busy), 64'd0);
    wait_done(lat);
    check("lock_next_latency", 64'(lat), 64'd18);
    check("lock_next_data", data_out, EXP_N);

    // reset during round 8
    @(negedge clk);
    issue(KEY, BLK);
    repeat (8) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_data", data_out, 64'd0);
    check("mid_rst_status", 64'(status), 64'd0);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (status) pulses++;
    end
    check("mid_no_status", 64'(pulses), 64'd0);
    issue(KEY, BLK);
    wait_done(lat);
    check("mid_fresh_latency", 64'(lat), 64'd18);
    check("mid_fresh_data", data_out, EXP);

    // back-to-back: second request in the completion cycle of the first
    @(negedge clk);
    issue(KEY_N, BLK_N);
    wait_done(lat);
    check("b2b_first_latency", 64'(lat), 64'd18);
    check("b2b_first_data", data_out, EXP_N);
    issue(KEY, BLK);
    check("b2b_first_held", data_out, EXP_N);
    wait_done(lat);
    check("b2b_second_gap", 64'(lat + 1), 64'd19);
    check("b2b_second_data", data_out, EXP);

`ifdef DES_DECRYPT_EN
    @(negedge clk);
    decrypt = 1'b1;
    issue(KEY, EXP);
    @(negedge clk);
    @(negedge clk);
    decrypt = 1'b0;
    wait_done(lat);
    check("dec_latency", 64'(lat), 64'd16);
    check("dec_data", data_out, BLK);
    @(negedge clk);
    decrypt = 1'b1;
    issue(KEY_N, EXP_N);
    wait_done(lat);
    decrypt = 1'b0;
    check("dec_n_data", data_out, BLK_N);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
